// File: rtl/axi_slave_write_ctrl.sv
// axi_slave_write_ctrl: AXI4 write-channel slave front end with burst address generation,
// window/protocol error checking and a first-word-fall-through queue of pending B responses.
module axi_slave_write_ctrl #(
    parameter int                ID_W        = 4,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                LEN_W       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] WIN_SIZE    = 32'h0000_1000,
    parameter int                BRESP_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [LEN_W-1:0]    awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic                i_core_ready,
    output logic                o_we,
    output logic [ADDR_W-1:0]   o_waddr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_strb
);
    localparam int SIZE_MAX = $clog2(DATA_W / 8);
    localparam int PTR_W    = $clog2(BRESP_DEPTH);

    typedef enum logic {S_ADDR, S_DATA} state_t;

    state_t            state, state_nxt;
    logic              live;
    logic [ID_W-1:0]   burst_id;
    logic [ADDR_W-1:0] burst_addr;
    logic [LEN_W-1:0]  burst_len;
    logic [2:0]        burst_size;
    logic [1:0]        burst_type;
    logic [LEN_W:0]    beat_cnt;
    logic              err;
    logic [ID_W-1:0]   fifo_id [BRESP_DEPTH];
    logic              fifo_err [BRESP_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic              aw_hs, w_hs, push, pop, aw_bad, len_ok;
    logic              in_win, over, beat_err, beat_ok, err_final;
    logic [ADDR_W-1:0] step, total, wrap_mask, addr_nxt;

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign push      = w_hs && wlast;
    assign pop       = bvalid && bready;
    assign len_ok    = awlen == LEN_W'(1) || awlen == LEN_W'(3) || awlen == LEN_W'(7) || awlen == LEN_W'(15);
    assign aw_bad    = awsize > 3'(SIZE_MAX) || awburst == 2'd3 ||
                       (awburst == 2'd2 && (!len_ok || (awaddr & ((ADDR_W'(1) << awsize) - ADDR_W'(1))) != '0));
    assign step      = ADDR_W'(1) << burst_size;
    assign total     = (ADDR_W'(burst_len) + ADDR_W'(1)) << burst_size;
    assign wrap_mask = total - ADDR_W'(1);
    assign addr_nxt  = burst_type == 2'd0 ? burst_addr :
                       burst_type == 2'd2 ? (burst_addr & ~wrap_mask) | ((burst_addr + step) & wrap_mask) :
                       (burst_addr & ~(step - ADDR_W'(1))) + step;
    // Offset compare keeps the window test correct even if BASE_ADDR+WIN_SIZE overflows.
    assign in_win    = (burst_addr - BASE_ADDR) < WIN_SIZE;
    assign over      = beat_cnt > {1'b0, burst_len};
    assign beat_err  = !in_win || over || (wlast && beat_cnt != {1'b0, burst_len});
    assign beat_ok   = !err && in_win && !over;
    assign err_final = err || beat_err;
    assign o_we      = w_hs && beat_ok;
    assign o_waddr   = burst_addr;
    assign o_wdata   = wdata;
    assign o_strb    = wstrb;
    assign bvalid    = count != '0;
    assign bid       = bvalid ? fifo_id[rd_ptr] : '0;
    assign bresp     = bvalid && fifo_err[rd_ptr] ? 2'b10 : 2'b00;

    // State register; live keeps awready low until the first clock after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_ADDR;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    // Handshake readies and next state; a full B queue (count MSB) blocks new bursts.
    always_comb begin
        awready   = live && state == S_ADDR && !count[PTR_W];
        wready    = state == S_DATA && i_core_ready;
        state_nxt = state;
        if (awvalid && awready) state_nxt = S_DATA;
        if (wvalid && wready && wlast) state_nxt = S_ADDR;
    end

    // Burst context: captured at AW, advanced per W beat; err accumulates every beat error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            burst_id   <= '0;
            burst_addr <= '0;
            burst_len  <= '0;
            burst_size <= '0;
            burst_type <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
        end else if (aw_hs) begin
            burst_id   <= awid;
            burst_addr <= awaddr;
            burst_len  <= awlen;
            burst_size <= awsize;
            burst_type <= awburst;
            beat_cnt   <= '0;
            err        <= aw_bad;
        end else if (w_hs) begin
            burst_addr <= addr_nxt;
            beat_cnt   <= &beat_cnt ? beat_cnt : beat_cnt + 1'b1;
            err        <= err_final;
        end
    end

    // B queue storage; contents need no reset because bvalid gates the head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_id[wr_ptr]  <= burst_id;
            fifo_err[wr_ptr] <= err_final;
        end
    end

    // B queue pointers and occupancy; reset flushes any pending responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
// tb_axi_slave_write_ctrl: directed bursts checked cycle-by-cycle against a burst-level model.
module tb_axi_slave_write_ctrl;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] WIN  = 32'h0000_1000;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready, i_core_ready, o_we;
    logic [31:0] o_waddr, o_wdata;
    logic [3:0]  o_strb;

    int total = 0;
    int bad = 0;

    b_t          mq[$];
    b_t          b_log[$];
    logic [31:0] wr_log[$];
    logic        m_busy = 1'b0, m_live = 1'b0, m_bad = 1'b0, m_err = 1'b0;
    logic [3:0]  m_id;
    logic [31:0] m_start;
    logic [2:0]  m_size;
    logic [1:0]  m_burst;
    int          m_len, m_k;

    always #5 clk = ~clk;

    axi_slave_write_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .i_core_ready(i_core_ready), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_strb(o_strb)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address of beat k from the burst rules, independent of any running address register.
    function automatic logic [31:0] beat_addr(input int k);
        logic [31:0] bytes, tot, base;
        bytes = 32'd1 << m_size;
        if (m_burst == 2'd0) return m_start;
        if (m_burst == 2'd2) begin
            tot  = 32'(m_len + 1) * bytes;
            base = m_start - (m_start % tot);
            return base + ((m_start - base + 32'(k) * bytes) % tot);
        end
        return k == 0 ? m_start : (m_start & ~(bytes - 32'd1)) + 32'(k) * bytes;
    endfunction

    // Compare process: check outputs against the model, then advance it by this cycle's handshakes.
    always @(negedge clk) begin : cmp
        logic [31:0] a;
        logic inwin, over, ok, whs, berr;
        if (!rst_ni) begin
            check("rst_awready", awready, 0);
            check("rst_wready", wready, 0);
            check("rst_bvalid", bvalid, 0);
            check("rst_o_we", o_we, 0);
            check("rst_bid", bid, 0);
            check("rst_bresp", bresp, 0);
            mq.delete();
            m_busy = 1'b0;
            m_live = 1'b0;
        end else begin
            check("awready", awready, m_live && !m_busy && mq.size() < 4);
            check("wready", wready, m_busy && i_core_ready);
            check("bvalid", bvalid, mq.size() != 0);
            if (bvalid && mq.size() != 0) begin
                check("bid", bid, mq[0].id);
                check("bresp", bresp, mq[0].resp);
            end
            whs   = wvalid && wready && m_busy;
            a     = beat_addr(m_k);
            inwin = (a - BASE) < WIN;
            over  = m_k > m_len;
            ok    = whs && !m_bad && !m_err && inwin && !over;
            check("o_we", o_we, ok);
            if (ok) begin
                check("o_waddr", o_waddr, a);
                check("o_wdata", o_wdata, wdata);
                check("o_strb", o_strb, wstrb);
            end
            if (o_we) wr_log.push_back(o_waddr);
            if (bvalid && bready) begin
                b_log.push_back('{bid, bresp});
                if (mq.size() != 0) void'(mq.pop_front());
            end
            if (whs) begin
                berr = !inwin || over || (wlast && m_k != m_len);
                if (wlast) begin
                    mq.push_back('{m_id, (m_bad || m_err || berr) ? 2'b10 : 2'b00});
                    m_busy = 1'b0;
                end else begin
                    m_err = m_err || berr;
                    m_k++;
                end
            end
            if (awvalid && awready) begin
                m_busy  = 1'b1;
                m_id    = awid;
                m_start = awaddr;
                m_len   = int'(awlen);
                m_size  = awsize;
                m_burst = awburst;
                m_k     = 0;
                m_err   = 1'b0;
                m_bad   = awsize > 3'd2 || awburst == 2'd3 ||
                          (awburst == 2'd2 && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                          (awburst == 2'd2 && (awaddr % (32'd1 << awsize)) != 0);
            end
            m_live = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        logic hs;
        n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        do begin
            @(negedge clk);
            hs = awready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 100);
        awvalid = 1'b0;
        check("aw_accepted", hs, 1);
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        logic hs;
        n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        do begin
            @(negedge clk);
            hs = wready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 100);
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("w_accepted", hs, 1);
    endtask

    task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] btype, input int last_at);
        do_aw(id, addr, len, size, btype);
        for (int k = 0; k <= last_at; k++)
            do_w(32'hD000_0000 ^ (addr << 8) ^ 32'(k), 4'(k + 1), k == last_at);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        b_log.delete();
    endtask

    task automatic check_b(input string name, input logic [3:0] id, input logic [1:0] resp);
        check({name, "_bcount"}, b_log.size(), 1);
        check({name, "_bid"}, b_log[0].id, id);
        check({name, "_bresp"}, b_log[0].resp, resp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] e_incr[4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        logic [31:0] e_wrap[4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
        logic        pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int          beats;
        logic        hs;
        rst_ni = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1; i_core_ready = 1'b1;
        idle(3);
        rst_ni = 1'b1;
        idle(2);

        clear_logs();
        burst(4'd3, 32'h100, 8'd3, 3'd2, 2'd1, 3);
        idle(3);
        check("incr_nwr", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) check("incr_addr", wr_log[i], e_incr[i]);
        check_b("incr", 4'd3, 2'b00);

        clear_logs();
        burst(4'd4, 32'h38, 8'd3, 3'd2, 2'd2, 3);
        idle(3);
        check("wrap_nwr", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) check("wrap_addr", wr_log[i], e_wrap[i]);
        check_b("wrap", 4'd4, 2'b00);

        clear_logs();
        burst(4'd5, 32'h38, 8'd2, 3'd2, 2'd2, 2);
        idle(3);
        check("wrap_len2_nwr", wr_log.size(), 0);
        check_b("wrap_len2", 4'd5, 2'b10);

        clear_logs();
        do_aw(4'd6, 32'h200, 8'd2, 3'd2, 2'd0);
        beats = 0;
        for (int c = 0; c < 5; c++) begin
            i_core_ready = pat[c];
            wdata = 32'h600 + 32'(c); wstrb = 4'hF; wlast = beats == 2; wvalid = 1'b1;
            @(negedge clk);
            hs = wvalid && wready;
            @(posedge clk);
            #1;
            if (hs) beats++;
        end
        wvalid = 1'b0; wlast = 1'b0; i_core_ready = 1'b1;
        idle(3);
        check("fixed_beats", beats, 3);
        check("fixed_nwr", wr_log.size(), 3);
        for (int i = 0; i < 3; i++) check("fixed_addr", wr_log[i], 32'h200);
        check_b("fixed", 4'd6, 2'b00);

        clear_logs();
        bready = 1'b0;
        for (int i = 1; i <= 4; i++) burst(4'(i), 32'h400 + 32'(16 * i), 8'd0, 3'd2, 2'd1, 0);
        idle(2);
        check("full_awready", awready, 0);
        check("full_bvalid", bvalid, 1);
        fork
            do_aw(4'd5, 32'h480, 8'd0, 3'd2, 2'd1);
            begin
                idle(3);
                bready = 1'b1;
            end
        join
        do_w(32'h5555_0000, 4'hF, 1'b1);
        idle(4);
        check("order_count", b_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("order_bid", b_log[i].id, 4'(i + 1));
            check("order_bresp", b_log[i].resp, 2'b00);
        end

        clear_logs();
        burst(4'd7, BASE + WIN - 32'd4, 8'd1, 3'd2, 2'd1, 1);
        idle(3);
        check("win_nwr", wr_log.size(), 1);
        check("win_addr", wr_log[0], 32'hFFC);
        check_b("win", 4'd7, 2'b10);

        clear_logs();
        burst(4'd8, 32'h40, 8'd3, 3'd2, 2'd1, 1);
        idle(3);
        check("early_nwr", wr_log.size(), 2);
        check("early_addr1", wr_log[1], 32'h44);
        check_b("early", 4'd8, 2'b10);

        clear_logs();
        burst(4'd9, 32'h80, 8'd1, 3'd3, 2'd1, 1);
        idle(3);
        check("size_nwr", wr_log.size(), 0);
        check_b("size", 4'd9, 2'b10);

        clear_logs();
        do_aw(4'd10, 32'h300, 8'd7, 3'd2, 2'd1);
        do_w(32'hA0, 4'hF, 1'b0);
        do_w(32'hA1, 4'hF, 1'b0);
        wdata = 32'hA2; wstrb = 4'hF; wvalid = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_o_we", o_we, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_wready", wready, 0);
        check("mid_rst_bvalid", bvalid, 0);
        wvalid = 1'b0;
        idle(2);
        rst_ni = 1'b1;
        clear_logs();
        idle(2);
        check("post_rst_awready", awready, 1);
        burst(4'd11, 32'h10, 8'd0, 3'd2, 2'd1, 0);
        idle(3);
        check("post_rst_nwr", wr_log.size(), 1);
        check("post_rst_addr", wr_log[0], 32'h10);
        check_b("post_rst", 4'd11, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_slave_write_ctrl.md
Name: axi_slave_write_ctrl

Overview:
- Parametrised AXI4 write-channel slave front end: accepts AW/W/B handshakes, generates per-beat core write strobes, and returns write responses.
- Supersedes the single-response write interface with configurable widths and FIXED/INCR/WRAP burst address generation.
- Adds core backpressure, address-window and protocol error detection (SLVERR), and a queue of up to BRESP_DEPTH pending B responses so new bursts are not stalled behind a blocked B channel.
- Sits between the AXI interconnect and a peripheral/memory core.

Parameters:
- ID_W, 4: AWID/BID width.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; power of two, >= 8.
- LEN_W, 8: AWLEN width.
- BASE_ADDR, 32'h0000_0000: first byte address of the legal window.
- WIN_SIZE, 32'h0000_1000: window size in bytes; power of two.
- BRESP_DEPTH, 4: pending-B FIFO depth; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- awid  in  ID_W  write ID
- awaddr  in  ADDR_W  burst start address
- awlen  in  LEN_W  beats minus 1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes
- wlast  in  1  last beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  response ID
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid  out  1  B valid
- bready  in  1  B ready
- i_core_ready  in  1  core can take a write this cycle
- o_we  out  1  core write enable, one per accepted beat
- o_waddr  out  ADDR_W  beat address
- o_wdata  out  DATA_W  beat data
- o_strb  out  DATA_W/8  beat strobes

Behaviour:
- Reset (async assert, sync release) values: awready=0, wready=0, bvalid=0, bid=0, bresp=0, o_we=0. State=S_ADDR, FIFO empty, beat counter 0.
- State machine has two states:
  - S_ADDR: awready = (fifo_count < BRESP_DEPTH). On AW handshake, register id/addr/len/size/burst, clear beat_cnt and err, go to S_DATA. awready is 0 in S_DATA.
  - S_DATA: wready = i_core_ready, combinational. On W handshake with wlast, push {id, err_final} into the FIFO and go to S_ADDR. The next AW is acceptable on the following cycle.
- Latency:
  - AW handshake in cycle N gives wready possible in N+1.
  - wlast handshake in cycle M gives bvalid=1 in M+1 if the FIFO was empty.
- Outputs o_waddr, o_wdata and o_strb are combinational from the current beat. o_we = wvalid && wready && beat_ok.
- beat_ok=0 in any of these cases (the beat is still handshaken but not written):
  - the burst is flagged bad;
  - the beat address falls outside [BASE_ADDR, BASE_ADDR+WIN_SIZE);
  - beat_cnt > awlen.
- Burst flagged bad (err set at AW) if any of:
  - awsize > log2(DATA_W/8);
  - awburst==3;
  - WRAP with awlen not in {1,3,7,15};
  - WRAP with start address not aligned to awsize.
- Runtime err set if any of:
  - any beat is out of window;
  - wlast arrives with beat_cnt != awlen;
  - beat_cnt exceeds awlen (writes suppressed until wlast).
- err_final = err OR current-beat error. Response is SLVERR if err_final, else OKAY.
- Next address after each W handshake:
  - FIXED: unchanged.
  - INCR: addr + (1<<size). The low bits of the first beat are aligned on the second beat. No 4 KB check.
  - WRAP: the low bits within total=(len+1)<<size wrap modulo total; upper bits are held.
- beat_cnt is LEN_W+1 bits and saturates.
- B FIFO is first-word-fall-through:
  - bvalid = !empty; bid/bresp come from the head entry and are stable while bvalid && !bready.
  - Push and pop in the same cycle keep the count.
  - Push never occurs when full (guaranteed by the awready gating).
- Reset mid-burst aborts the burst. No B is produced for it; the FIFO is flushed.

Test Plan:
- Single INCR, addr 0x100, len 3, size 2, i_core_ready=1, bready=1 -> o_we on 4 cycles at o_waddr 0x100/0x104/0x108/0x10C; bid=awid, bresp=00 one cycle after wlast.
- WRAP, addr 0x38, len 3, size 2 -> o_waddr 0x38, 0x3C, 0x30, 0x34; bresp OKAY. Repeat with len 2 -> no o_we, bresp=10.
- FIXED, addr 0x200, len 2, i_core_ready toggling 1,0,1,0,1 -> wready follows i_core_ready; exactly 3 o_we, all at 0x200.
- bready=0, five back-to-back single-beat bursts with IDs 1..5 (BRESP_DEPTH=4) -> 4 accepted; awready=0 while the FIFO holds 4; after bready=1 the B order is 1,2,3,4, then ID 5 is accepted.
- Burst at BASE_ADDR+WIN_SIZE-4, len 1, size 2 -> first beat written, second has o_we=0; bresp=10. Early wlast on beat 1 of len 3 -> bresp=10. awsize=3 with DATA_W=32 -> no writes, bresp=10.
- rst_ni low mid-burst after beat 2 of len 7 -> all outputs 0 immediately; after release awready=1 and a new burst completes normally with no stale B.
